// File: rtl/coef_bank_banda_if.sv
// Serial coefficient write channel (valid/ready) between host and coefficient bank.
// Latency: n/a (signal bundle only).
// Backpressure: the host holds wr_data/wr_last while wr_valid=1 and wr_ready=0.
//
// Signals:
//   wr_data  - signed coefficient word, Width bits
//   wr_valid - wr_data is valid
//   wr_last  - marks the final (10th) word of a frame
//   wr_ready - bank can accept a word this cycle
interface coef_bank_banda_if #(
  parameter int Width = 32
);
  logic [Width-1:0] wr_data;
  logic             wr_valid;
  logic             wr_last;
  logic             wr_ready;

  modport master (output wr_data, output wr_valid, output wr_last, input wr_ready);
  modport slave  (input wr_data, input wr_valid, input wr_last, output wr_ready);
endinterface

// File: rtl/coef_bank_banda.sv
// Coefficient bank for the band-pass biquad pair: serial shadow load, atomic commit on enable.
// Latency: active set and upd change one edge after the first enable seen with a full frame pending.
// Backpressure: wr_ready=1 while collecting a frame, 0 while a full frame waits for enable.
//
// Ports:
//   clk, rst (async, active low), enable (sample strobe shared with the band filter)
//   wr   - slave side of coef_bank_banda_if (wr_data/wr_valid/wr_last/wr_ready)
//   La1..Lb2, Ha1..Hb2 - active low/high section coefficients
//   pending - full frame in shadow awaiting enable; upd - one-cycle commit pulse;
//   err - sticky frame error, cleared by the first word of the next frame
// Build option: define COEF_STAB_CHECK_EN to reject frames with |La2| or |Ha2| >= 1.0.
module coef_bank_banda #(
  parameter int p     = 13,
  parameter int f     = 18,
  parameter int Width = p + f + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  coef_bank_banda_if.slave wr,
  output logic [Width-1:0] La1,
  output logic [Width-1:0] La2,
  output logic [Width-1:0] Lb0,
  output logic [Width-1:0] Lb1,
  output logic [Width-1:0] Lb2,
  output logic [Width-1:0] Ha1,
  output logic [Width-1:0] Ha2,
  output logic [Width-1:0] Hb0,
  output logic [Width-1:0] Hb1,
  output logic [Width-1:0] Hb2,
  output logic             pending,
  output logic             upd,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  // 1.0 in the fixed-point format; b0 resets to this so both sections pass through.
  localparam logic [Width-1:0] ONE = {{(Width-1){1'b0}}, 1'b1} << f;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic             wr_ready_q;
  logic             pending_q;
  logic             upd_q;
  logic             err_q;
  logic [Width-1:0] shadow_q [10];
  logic [Width-1:0] active_q [10];

  logic             xfer;
  logic             frame_bad;

  assign xfer = wr.wr_valid && wr_ready_q;

`ifdef COEF_STAB_CHECK_EN
  // Both a2 words are already in shadow by the time the 10th word arrives.
  logic a2_ok;
  assign a2_ok = ($signed(shadow_q[1]) < $signed(ONE)) && ($signed(shadow_q[1]) > -$signed(ONE)) &&
                 ($signed(shadow_q[6]) < $signed(ONE)) && ($signed(shadow_q[6]) > -$signed(ONE));
`endif

  // A frame is bad if wr_last disagrees with the word position (only the 10th word may carry it).
  always_comb begin
    frame_bad = (idx_q == 4'd9) ? !wr.wr_last : wr.wr_last;
`ifdef COEF_STAB_CHECK_EN
    if ((idx_q == 4'd9) && !a2_ok) frame_bad = 1'b1;
`else
    // Unchecked build: any a2 value is accepted.
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      wr_ready_q <= 1'b1;
      pending_q  <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= (i == 2 || i == 7) ? ONE : '0;
      end
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // wr_last on the first word is not examined; position checks start with word 2.
          if (xfer) begin
            err_q       <= 1'b0;
            shadow_q[0] <= wr.wr_data;
            idx_q       <= 4'd1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            shadow_q[idx_q] <= wr.wr_data;
            if (frame_bad) begin
              err_q   <= 1'b1;
              idx_q   <= 4'd0;
              state_q <= IDLE;
            end else if (idx_q == 4'd9) begin
              wr_ready_q <= 1'b0;
              pending_q  <= 1'b1;
              state_q    <= PEND;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        PEND: begin
          // Entered on the 10th-word edge, so an enable on that same edge cannot commit.
          if (enable) begin
            for (int i = 0; i < 10; i++) active_q[i] <= shadow_q[i];
            upd_q      <= 1'b1;
            pending_q  <= 1'b0;
            wr_ready_q <= 1'b1;
            idx_q      <= 4'd0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign pending     = pending_q;
  assign upd         = upd_q;
  assign err         = err_q;

  assign La1 = active_q[0];
  assign La2 = active_q[1];
  assign Lb0 = active_q[2];
  assign Lb1 = active_q[3];
  assign Lb2 = active_q[4];
  assign Ha1 = active_q[5];
  assign Ha2 = active_q[6];
  assign Hb0 = active_q[7];
  assign Hb1 = active_q[8];
  assign Hb2 = active_q[9];

endmodule
